// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM sequencing fetch/decode/execute over a shared memory port.
// Define MIPS_MC_MULDIV_EN to build the iterative multiply sequencer (MULT state + counter).
module mips_mc_ctrl #(
    parameter int MUL_CYCLES = 32,
    parameter int ALUCTR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                IorD,
    output logic                IRWr,
    output logic                PCWr,
    output logic [1:0]          PCSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                ExtOp,
    output logic                RegWr,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic                HiLoWr,
    output logic                illegal,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_BR     = 4'd5,
        S_JMP    = 4'd6,
        S_MULT   = 4'd7,
        S_ILL    = 4'd8
    } state_t;

    typedef struct packed {
        logic                mem_req;
        logic                mem_we;
        logic                iord;
        logic                pc_wr;
        logic [1:0]          pc_src;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALUCTR_W-1:0] alu_ctr;
        logic                ext_op;
        logic                reg_wr;
        logic [1:0]          reg_dst;
        logic [1:0]          mem_to_reg;
        logic                hilo_wr;
        logic                illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                           OP_LW    = 6'h23, OP_SW  = 6'h2b;
    localparam logic [5:0] FN_JR  = 6'h08, FN_MULT = 6'h18, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2a;

    localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(0), ALU_SUB = ALUCTR_W'(1),
                                    ALU_AND = ALUCTR_W'(2), ALU_OR  = ALUCTR_W'(3),
                                    ALU_SLT = ALUCTR_W'(4), ALU_LUI = ALUCTR_W'(5);

    state_t state_q, state_next, state_d;
    ctrl_t  ctrl_q, ctrl_next;

    logic [5:0] op, fn;
    logic is_rtype, r_alu, r_jr, r_mult;
    logic is_lw, is_sw, is_ori, is_lui, i_alu, is_beq, is_bne, is_j, is_jal;
    logic [ALUCTR_W-1:0] exe_alu;
    logic fetch_done, br_take;

    assign op       = instr[31:26];
    assign fn       = instr[5:0];
    assign is_rtype = (op == OP_RTYPE);
    assign r_alu    = is_rtype && (fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT});
    assign r_jr     = is_rtype && (fn == FN_JR);
    assign r_mult   = is_rtype && (fn == FN_MULT);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign i_alu    = is_lw || is_sw || is_ori || is_lui || (op == OP_ADDIU);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);

`ifdef MIPS_MC_MULDIV_EN
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_next;
`endif

    always_comb begin
        exe_alu = ALU_ADD;
        if (is_rtype) begin
            case (fn)
                FN_SUBU: exe_alu = ALU_SUB;
                FN_AND:  exe_alu = ALU_AND;
                FN_OR:   exe_alu = ALU_OR;
                FN_SLT:  exe_alu = ALU_SLT;
                default: exe_alu = ALU_ADD;
            endcase
        end else if (is_ori) begin
            exe_alu = ALU_OR;
        end else if (is_lui) begin
            exe_alu = ALU_LUI;
        end
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state_q;
`ifdef MIPS_MC_MULDIV_EN
        cnt_next = cnt_q;
`endif
        case (state_q)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (r_alu || i_alu)              state_next = S_EXE;
                else if (r_jr || is_j || is_jal) state_next = S_JMP;
                else if (is_beq || is_bne)       state_next = S_BR;
`ifdef MIPS_MC_MULDIV_EN
                else if (r_mult) begin
                    state_next = S_MULT;
                    cnt_next   = CNT_W'(MUL_CYCLES - 1);
                end
`endif
                else                             state_next = S_ILL;
            end
            S_EXE:    state_next = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
`ifdef MIPS_MC_MULDIV_EN
            S_MULT: begin
                if (cnt_q == '0) state_next = S_FETCH;
                else             cnt_next   = cnt_q - 1'b1;
            end
`endif
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs are registered: decode the state being entered so they line up with state_q.
    assign state_d = rst ? state_next : S_FETCH;

    always_comb begin
        ctrl_next = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_next.mem_req   = 1'b1;
                ctrl_next.alu_src_b = 2'd1;
            end
            S_DECODE: begin
                ctrl_next.alu_src_b = 2'd3;
                ctrl_next.ext_op    = 1'b1;
            end
            S_EXE: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_ctr   = exe_alu;
                if (!is_rtype) begin
                    ctrl_next.alu_src_b = 2'd2;
                    ctrl_next.ext_op    = !(is_ori || is_lui);
                end
            end
            S_MEM: begin
                ctrl_next.mem_req = 1'b1;
                ctrl_next.iord    = 1'b1;
                ctrl_next.mem_we  = is_sw;
            end
            S_WB: begin
                ctrl_next.reg_wr     = 1'b1;
                ctrl_next.reg_dst    = is_rtype ? 2'd1 : 2'd0;
                ctrl_next.mem_to_reg = is_lw ? 2'd1 : 2'd0;
            end
            S_BR: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_ctr   = ALU_SUB;
            end
            S_JMP: begin
                ctrl_next.pc_wr  = 1'b1;
                ctrl_next.pc_src = r_jr ? 2'd3 : 2'd2;
                if (is_jal) begin
                    ctrl_next.reg_wr     = 1'b1;
                    ctrl_next.reg_dst    = 2'd2;
                    ctrl_next.mem_to_reg = 2'd2;
                end
            end
`ifdef MIPS_MC_MULDIV_EN
            S_MULT:  ctrl_next.hilo_wr = (cnt_next == '0);
`endif
            S_ILL:   ctrl_next.illegal = 1'b1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_next;
`ifdef MIPS_MC_MULDIV_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_next;
            ctrl_q  <= ctrl_next;
`ifdef MIPS_MC_MULDIV_EN
            cnt_q   <= cnt_next;
`endif
        end
    end

    // IR/PC loads and the branch decision must see mem_ready and zero in the same cycle.
    assign fetch_done = (state_q == S_FETCH) && mem_ready;
    assign br_take    = (state_q == S_BR) && ((is_beq && zero) || (is_bne && !zero));

    assign mem_req  = ctrl_q.mem_req;
    assign mem_we   = ctrl_q.mem_we;
    assign IorD     = ctrl_q.iord;
    assign IRWr     = fetch_done;
    assign PCWr     = ctrl_q.pc_wr || fetch_done || br_take;
    assign PCSrc    = br_take ? 2'd1 : ctrl_q.pc_src;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign ALUctr   = ctrl_q.alu_ctr;
    assign ExtOp    = ctrl_q.ext_op;
    assign RegWr    = ctrl_q.reg_wr;
    assign RegDst   = ctrl_q.reg_dst;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign illegal  = ctrl_q.illegal;
    assign state    = state_q;

    logic unused_ok;
`ifdef MIPS_MC_MULDIV_EN
    assign HiLoWr    = ctrl_q.hilo_wr;
    assign unused_ok = ^instr[25:6];
`else
    assign HiLoWr    = 1'b0;
    assign unused_ok = ^{instr[25:6], r_mult, ctrl_q.hilo_wr, MUL_CYCLES != 0};
`endif

endmodule
